// File: rtl/inv_shift_rows_stage.sv
// InvShiftRows stage for the AES inverse cipher datapath.
// Rotates row r of the column-major AES state right by r bytes. A valid/ready
// handshake and a 2-entry output FIFO let the stage absorb backpressure.
// A sideband tag (round index) travels unchanged with each word.
module inv_shift_rows_stage #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic [TAG_W-1:0]  tag_out
);

  // The permutation is defined only for a 128-bit AES state.
  if (DATA_W != 128) begin : g_width_check
    $error("inv_shift_rows_stage: DATA_W must be 128");
  end

  // FIFO occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t              occ;
  occ_t              occ_next;

  logic [DATA_W-1:0] head_data;
  logic [TAG_W-1:0]  head_tag;
  logic [DATA_W-1:0] tail_data;
  logic [TAG_W-1:0]  tail_tag;
  logic [DATA_W-1:0] perm_data;

  logic              push;
  logic              pop;
  logic              load_head_in;
  logic              load_head_tail;
  logic              load_tail_in;

  // Byte i sits at bits [(15-i)*8 +: 8], i = 4*col + row. Output byte at
  // (col, row) comes from input column (col - row) mod 4, same row.
  function automatic logic [DATA_W-1:0] inv_shift_rows(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      int unsigned col;
      int unsigned row;
      int unsigned src;
      col = i / 4;
      row = i % 4;
      src = 4 * ((col + 4 - row) % 4) + row;
      o[(15 - i) * 8 +: 8] = s[(15 - src) * 8 +: 8];
    end
    return o;
  endfunction

  // Words are permuted before storage so the head register drives data_out directly.
  always_comb begin
    perm_data = inv_shift_rows(data_in);
  end

  assign ready_out = !reset && (occ != FULL);
  assign valid_out = (occ != EMPTY);
  assign data_out  = head_data;
  assign tag_out   = head_tag;

  assign push = valid_in && ready_out;
  assign pop  = valid_out && ready_in;

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= EMPTY;
    end else begin
      occ <= occ_next;
    end
  end

  // Next occupancy and entry load selects.
  always_comb begin
    occ_next       = occ;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail_in   = 1'b0;
    case (occ)
      EMPTY: begin
        if (push) begin
          load_head_in = 1'b1;
          occ_next     = ONE;
        end
      end
      ONE: begin
        // Push with pop replaces the head in place: no bubble, count stays 1.
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          load_tail_in = 1'b1;
          occ_next     = FULL;
        end else if (pop) begin
          occ_next     = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          load_head_tail = 1'b1;
          occ_next       = ONE;
        end
      end
      default: begin
        occ_next = EMPTY;
      end
    endcase
  end

  // Head entry: holds its value while stalled or empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_data <= '0;
      head_tag  <= '0;
    end else if (load_head_in) begin
      head_data <= perm_data;
      head_tag  <= tag_in;
    end else if (load_head_tail) begin
      head_data <= tail_data;
      head_tag  <= tail_tag;
    end
  end

  // Tail entry: only filled when the head is occupied and not draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      tail_data <= '0;
      tail_tag  <= '0;
    end else if (load_tail_in) begin
      tail_data <= perm_data;
      tail_tag  <= tag_in;
    end
  end

endmodule

// File: doc/inv_shift_rows_stage.md
Name: inv_shift_rows_stage

Overview:
- Decryption-side InvShiftRows stage for the AES inverse cipher datapath. It undoes the encryption-side ShiftRows byte permutation.
- Adds a valid/ready handshake and a 2-entry output buffer, so the stage can sit between InvSubBytes/AddRoundKey stages that apply backpressure.
- A per-word tag (round index) travels alongside the data so downstream stages can select round keys and skip InvMixColumns on the last round.

Parameters:
- DATA_W, 128, state width; only 128 is legal; any other value is a synthesis-time error.
- TAG_W, 4, width of the sideband tag carried with each word.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  upstream word valid.
- ready_out  output  1  stage can accept a word this cycle.
- data_in  input  DATA_W  AES state, byte i = data_in[(15-i)*8+7 : (15-i)*8], column-major (i = 4*col + row).
- tag_in  input  TAG_W  sideband tag accompanying data_in.
- valid_out  output  1  downstream word valid.
- ready_in  input  1  downstream accepts the word this cycle.
- data_out  output  DATA_W  permuted state, same byte ordering.
- tag_out  output  TAG_W  tag of the word on data_out.

Behaviour:
- Reset (synchronous, active-high): count=0, valid_out=0, data_out=0, tag_out=0, both buffer entries cleared, ready_out=0 while reset is high.
- Reset mid-operation: any buffered words are discarded, with no partial output.
- Permutation: with S[i] the input bytes, the output columns from MSB are:
  - col0 = {S0,S13,S10,S7}
  - col1 = {S4,S1,S14,S11}
  - col2 = {S8,S5,S2,S15}
  - col3 = {S12,S9,S6,S3}
  - Row r is rotated right by r bytes.
  - The permutation is applied on the input side; words are stored already permuted. The tag is passed unchanged.
- Handshake:
  - Push when valid_in && ready_out. Pop when valid_out && ready_in.
  - Both handshakes are sampled at the clock edge.
- Buffer:
  - 2-entry FIFO with occupancy count 0..2. Entry 0 (head) drives data_out and tag_out directly from registers.
  - ready_out = !reset && (count != 2). It depends only on registered state and is not combinational from ready_in.
  - valid_out = (count != 0), registered.
- Latency and throughput:
  - A word pushed into an empty buffer appears on valid_out/data_out the following cycle.
  - Sustained throughput is 1 word/clk when ready_in is held high.
- Stability: while valid_out=1 && ready_in=0, data_out and tag_out are held constant and valid_out stays 1.
- Occupancy cases:
  - count=0, push: word goes to head; count=1.
  - count=1, push only: word goes to entry 1; count=2.
  - count=1, pop only: count=0; valid_out drops the next cycle.
  - count=1, push+pop: the new word replaces the head; count stays 1; no bubble.
  - count=2, pop: entry 1 moves to head; count=1. No push is possible, since ready_out=0.
  - count=2, valid_in=1: not accepted; upstream must hold the word.
- Values held when empty: data_out and tag_out keep their last value when count=0. Verification checks data_out only when valid_out=1.
- Ordering: strict FIFO. No word is dropped or duplicated under any valid/ready pattern.

Test Plan:
- Reset then idle: assert reset 2 cycles -> valid_out=0, data_out=0, ready_out=0 during reset; ready_out=1 on the first cycle after.
- Single word: data_in=0x00010203_04050607_08090a0b_0c0d0e0f, tag_in=3, ready_in=1 -> next cycle valid_out=1, data_out=0x000d0a07_04010e0b_0805020f_0c090603, tag_out=3.
- Round trip: feed the encryption-side ShiftRows output of 0x00112233_44556677_8899aabb_ccddeeff -> data_out equals the original word.
- Backpressure: ready_in=0 while pushing 3 consecutive words -> ready_out=0 after 2 accepts, data_out stable on word 1. Then ready_in=1 -> words 1, 2, 3 emerge in order with correct tags.
- Streaming: 64 random words with valid_in=1 and ready_in=1 -> one output per clock, 1-cycle latency, permutation and tags match the model.
- Random valid/ready and reset: random valid_in/ready_in with reset asserted mid-stream -> scoreboard matches the model, buffer empty after reset, no stale word emitted.
